trimux_n_reg: RTL

TRIMUX_N_REG -- requirements
Module: trimux_n_reg

---
 rtl/trimux_n_reg.sv | 133 +++++++++++++
 1 files changed

// File: rtl/trimux_n_reg.sv
// Registered N-channel multiplexer onto a shared tristate bus with IDLE/DRIVE/TURN handshake.
// Optional auto-scan of the select register is compiled in with `define TRIMUX_SCAN_EN.
module trimux_n_reg #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 scan,
  input  logic [SELW-1:0]      sel_in,
  input  logic                 sel_load,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ack,
  output logic [WIDTH-1:0]     bus,
  output logic                 bus_oe,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      sel_cur,
  output logic                 sel_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_oe;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_sel;
  logic             r_err;

  logic             w_scan;
  logic             w_loadOk;
  logic             w_loadBad;
  logic             w_done;
  logic [SELW-1:0]  w_selInc;
  logic [SELW-1:0]  w_capSel;
  logic             w_capOk;
  logic [WIDTH-1:0] w_capData;
  logic             w_selStep;

`ifdef TRIMUX_SCAN_EN
  assign w_scan = scan;
`else
  assign w_scan = scan & 1'b0;
`endif

  assign w_loadOk  = sel_load && (int'(sel_in) < NCH);
  assign w_loadBad = sel_load && !w_loadOk;
  assign w_done    = (r_state == DRIVE) && out_ready;
  assign w_selInc  = (r_sel == SELW'(NCH - 1)) ? '0 : r_sel + 1'b1;

  // A back-to-back capture reads the channel the select register is about to
  // move to; a same-cycle sel_load keeps the old channel for this capture.
  assign w_capSel  = (w_done && w_scan && !w_loadOk) ? w_selInc : r_sel;
  assign w_capOk   = rst_n && en && in_valid[w_capSel] &&
                     ((r_state == IDLE) || w_done);
  assign w_capData = in_data[w_capSel*WIDTH +: WIDTH];

  assign w_selStep = w_scan &&
                     (w_done || ((r_state == IDLE) && !in_valid[r_sel]));

  assign in_ack    = w_capOk ? (NCH'(1) << w_capSel) : '0;
  assign bus       = r_oe ? r_data : 'z;
  assign bus_oe    = r_oe;
  assign out_valid = r_oe;
  assign sel_cur   = r_sel;
  assign sel_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_oe    <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capOk) begin
            r_state <= DRIVE;
            r_oe    <= 1'b1;
            r_data  <= w_capData;
          end
        end
        DRIVE: begin
          if (!en) begin
            r_state <= TURN;
            r_oe    <= 1'b0;
          end else if (out_ready) begin
            if (w_capOk) begin
              r_data <= w_capData;
            end else begin
              r_state <= TURN;
              r_oe    <= 1'b0;
            end
          end
        end
        TURN: begin
          r_state <= IDLE;
          r_oe    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
    end else if (w_loadOk) begin
      r_sel <= sel_in;
    end else if (w_selStep) begin
      r_sel <= w_selInc;
    end
  end

  // Sticky until reset so software can detect any out-of-range select request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_loadBad) begin
      r_err <= 1'b1;
    end
  end

endmodule
